pos_cache_mc: RTL and testbench

- Parametrised double-buffered particle position cache for one cell; successor of the fixed-coordinate, single-channel position caches.
- Serves reads to the force pipeline from the active bank while collecting motion-update particles from NUM_IN_CH broadcast channels into the shadow bank.
- Writes the particle count to address 0 of the shadow bank, then swaps banks.
- Sits between the motion-update broadcast network and the range-limited force evaluation units.

---
 rtl/pos_cache_pkg.sv | 24 ++
 rtl/pos_cache_bank.sv | 31 +++
 rtl/pos_cache_mc.sv | 194 +++++++++++++++++++
 tb/tb_pos_cache_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pos_cache_pkg.sv
// Shared types and constants for the double-buffered particle position cache.
// Stored words are {z,y,x}; the cell match key is {x,y,z}.
package pos_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DRAIN,
        WR_COUNT,
        SWAP
    } pc_state_t;

    localparam int COORDS     = 3;
    localparam int COUNT_ADDR = 0;

    function automatic int word_w(input int data_width);
        return COORDS * data_width;
    endfunction

    function automatic int key_w(input int cell_id_width);
        return COORDS * cell_id_width;
    endfunction

endpackage

// File: rtl/pos_cache_bank.sv
// Single-port synchronous position bank; 1-cycle registered read that holds when rden is low.
// No backpressure: one access (read or write) per cycle as steered by the owner.
module pos_cache_bank #(
    parameter int WORD_W     = 96,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rden,
    input  logic                  wren,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wren)
            mem[addr] <= wdata;
    end

    // Only the output register is reset; stored contents survive reset.
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (rden)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/pos_cache_mc.sv
// Double-buffered cell position cache: reads from the active bank, collects NUM_IN_CH channels into the shadow bank, then swaps.
// Read latency 1; in_ready drops when the ingress queue cannot take NUM_IN_CH words. POS_CACHE_OVF_DETECT_EN builds overflow detection.
module pos_cache_mc
    import pos_cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int PARTICLE_NUM  = 220,
    parameter int CELL_ID_WIDTH = 4,
    parameter logic [CELL_ID_WIDTH-1:0] CELL_X = 1,
    parameter logic [CELL_ID_WIDTH-1:0] CELL_Y = 1,
    parameter logic [CELL_ID_WIDTH-1:0] CELL_Z = 1,
    parameter int NUM_IN_CH     = 2,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                motion_update_enable,
    input  logic [ADDR_WIDTH-1:0]               in_read_address,
    input  logic                                in_rden,
    output logic [3*DATA_WIDTH-1:0]             out_particle_info,
    input  logic [NUM_IN_CH*3*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_IN_CH*3*CELL_ID_WIDTH-1:0] in_data_dst_cell,
    input  logic [NUM_IN_CH-1:0]                in_data_valid,
    output logic                                in_ready,
    output logic                                swap_done,
    output logic [ADDR_WIDTH-1:0]               particle_count,
    output logic                                overflow
);

    localparam int WORD_W = word_w(DATA_WIDTH);
    localparam int KEY_W  = key_w(CELL_ID_WIDTH);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [KEY_W-1:0] CELL_KEY = {CELL_X, CELL_Y, CELL_Z};

    pc_state_t             state;
    logic                  active_bank;
    logic                  rd_sel;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] count_m1;

    logic [WORD_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        fifo_cnt;
    logic [PTR_W:0]        fifo_cnt_nxt;
    logic [PTR_W:0]        push_num;
    logic [PTR_W:0]        slot [NUM_IN_CH];
    logic [NUM_IN_CH-1:0]  want;
    logic [NUM_IN_CH-1:0]  hit;
    logic                  cap_state;
    logic                  pop;
    logic                  discard;

    logic                  bank_wren;
    logic [ADDR_WIDTH-1:0] bank_waddr;
    logic [WORD_W-1:0]     bank_wdata;
    logic [WORD_W-1:0]     bank_rdata [2];

    assign cap_state = ((state == IDLE) || (state == COLLECT)) && motion_update_enable;
    assign count_m1  = wr_cnt - ADDR_WIDTH'(1);

    // Each hit gets a slot offset equal to the number of lower-numbered hits, keeping channel order.
    always_comb begin
        want     = '0;
        hit      = '0;
        push_num = '0;
        for (int c = 0; c < NUM_IN_CH; c++) begin
            want[c] = in_data_valid[c] && (in_data_dst_cell[c*KEY_W +: KEY_W] == CELL_KEY);
            hit[c]  = want[c] && cap_state && in_ready;
            slot[c] = push_num;
            push_num = push_num + {{PTR_W{1'b0}}, hit[c]};
        end
    end

    assign pop          = (fifo_cnt != '0) &&
                          ((state == IDLE) || (state == COLLECT) || (state == DRAIN));
    assign discard      = pop && (int'(wr_cnt) > PARTICLE_NUM);
    assign fifo_cnt_nxt = fifo_cnt + push_num - {{PTR_W{1'b0}}, pop};

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_IN_CH; c++) begin
            if (hit[c])
                fifo_mem[wr_ptr + slot[c][PTR_W-1:0]] <= in_data[c*WORD_W +: WORD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + push_num[PTR_W-1:0];
            rd_ptr   <= rd_ptr + {{(PTR_W-1){1'b0}}, pop};
            fifo_cnt <= fifo_cnt_nxt;
        end
    end

    always_comb begin
        bank_wren  = 1'b0;
        bank_waddr = wr_cnt;
        bank_wdata = fifo_mem[rd_ptr];
        if (state == WR_COUNT) begin
            bank_wren  = 1'b1;
            bank_waddr = ADDR_WIDTH'(COUNT_ADDR);
            bank_wdata = WORD_W'(count_m1);
        end else if (pop && !discard) begin
            bank_wren  = 1'b1;
        end
    end

    // in_ready looks one state ahead: SWAP returns to IDLE, COLLECT keeps capturing only while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            active_bank    <= 1'b0;
            wr_cnt         <= ADDR_WIDTH'(1);
            in_ready       <= 1'b1;
            swap_done      <= 1'b0;
            particle_count <= '0;
        end else begin
            swap_done <= 1'b0;
            in_ready  <= ((state == IDLE) || (state == SWAP) ||
                          ((state == COLLECT) && motion_update_enable)) &&
                         (int'(fifo_cnt_nxt) <= FIFO_DEPTH - NUM_IN_CH);
            if (pop && !discard)
                wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
            case (state)
                IDLE:     if (motion_update_enable) state <= COLLECT;
                COLLECT:  if (!motion_update_enable) state <= DRAIN;
                DRAIN:    if (fifo_cnt == '0) state <= WR_COUNT;
                WR_COUNT: state <= SWAP;
                SWAP: begin
                    active_bank    <= ~active_bank;
                    particle_count <= count_m1;
                    swap_done      <= 1'b1;
                    wr_cnt         <= ADDR_WIDTH'(1);
                    state          <= IDLE;
                end
                default:  state <= IDLE;
            endcase
        end
    end

`ifdef POS_CACHE_OVF_DETECT_EN
    logic ovf_q;
    logic push_full;

    assign push_full = (int'(fifo_cnt) == FIFO_DEPTH) && cap_state && (|want);

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if ((state == IDLE) && motion_update_enable)
            ovf_q <= 1'b0;
        else if (discard || push_full)
            ovf_q <= 1'b1;
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_act;
        assign is_act = (active_bank == 1'(b));

        pos_cache_bank #(
            .WORD_W     (WORD_W),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .addr  (is_act ? in_read_address : bank_waddr),
            .rden  (is_act && in_rden),
            .wren  (!is_act && bank_wren),
            .wdata (bank_wdata),
            .rdata (bank_rdata[b])
        );
    end

    // Output follows the bank that served the last read, so it holds across a swap.
    always_ff @(posedge clk) begin
        if (rst)
            rd_sel <= 1'b0;
        else if (in_rden)
            rd_sel <= active_bank;
    end

    assign out_particle_info = bank_rdata[rd_sel];

endmodule

// File: tb/tb_pos_cache_mc.sv
// Scoreboard bench for pos_cache_mc: accepted hits are queued in arrival/channel order and compared
// against bank contents after each swap; a PARTICLE_NUM=4 instance shares the stimulus for clipping.
module tb_pos_cache_mc;

    localparam int WW  = 96;
    localparam int KW  = 12;
    localparam int NCH = 2;
    localparam logic [KW-1:0] CELL_KEY = 12'h111;
    localparam logic [KW-1:0] BAD_KEY  = 12'h211;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              motion_update_enable = 1'b0;
    logic [7:0]        in_read_address = '0;
    logic              in_rden = 1'b0;
    logic [NCH*WW-1:0] in_data = '0;
    logic [NCH*KW-1:0] in_data_dst_cell = '0;
    logic [NCH-1:0]    in_data_valid = '0;

    logic [WW-1:0] out_info, out_s;
    logic          in_ready, in_ready_s;
    logic          swap_done, swap_done_s;
    logic [7:0]    pcount, pcount_s;
    logic          ovf, ovf_s;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] saved_q[$];
    bit saw_not_ready;

    always #5 clk = ~clk;

    pos_cache_mc dut (
        .clk(clk), .rst(rst), .motion_update_enable(motion_update_enable),
        .in_read_address(in_read_address), .in_rden(in_rden), .out_particle_info(out_info),
        .in_data(in_data), .in_data_dst_cell(in_data_dst_cell), .in_data_valid(in_data_valid),
        .in_ready(in_ready), .swap_done(swap_done), .particle_count(pcount), .overflow(ovf)
    );

    pos_cache_mc #(.PARTICLE_NUM(4)) dut_small (
        .clk(clk), .rst(rst), .motion_update_enable(motion_update_enable),
        .in_read_address(in_read_address), .in_rden(in_rden), .out_particle_info(out_s),
        .in_data(in_data), .in_data_dst_cell(in_data_dst_cell), .in_data_valid(in_data_valid),
        .in_ready(in_ready_s), .swap_done(swap_done_s), .particle_count(pcount_s), .overflow(ovf_s)
    );

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit want(input int mode, input int i, input int c);
        case (mode)
            0:       return (c == 0) ? (i == 1 || i == 4 || i == 6) : (i == 4 || i == 8);
            1, 2, 4: return 1'b1;
            3:       return i < 3;
            default: return (c == 1) && (i == 0 || i == 2);
        endcase
    endfunction

    // Valid/ready sender: a channel holds its word until it sees in_ready at a clock edge.
    task automatic run_window(input int mode, input int ncyc);
        logic [WW-1:0] pdat [NCH];
        logic [KW-1:0] pdst [NCH];
        bit            pend [NCH];
        bit            rdy;
        for (int c = 0; c < NCH; c++) begin
            pend[c] = 1'b0;
            pdat[c] = '0;
            pdst[c] = CELL_KEY;
        end
        saw_not_ready = 1'b0;
        motion_update_enable = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!pend[c] && want(mode, i, c)) begin
                    pend[c] = 1'b1;
                    pdat[c] = {$urandom, $urandom, $urandom};
                    pdst[c] = (mode == 2) ? BAD_KEY : CELL_KEY;
                end
                in_data[c*WW +: WW]          = pdat[c];
                in_data_dst_cell[c*KW +: KW] = pdst[c];
                in_data_valid[c]             = pend[c];
            end
            rdy = in_ready;
            if (!rdy) saw_not_ready = 1'b1;
            @(posedge clk); #1;
            if (rdy) begin
                for (int c = 0; c < NCH; c++) begin
                    if (pend[c]) begin
                        if (pdst[c] == CELL_KEY) exp_q.push_back(pdat[c]);
                        pend[c] = 1'b0;
                    end
                end
            end
            if (mode == 4 && i == 0) check("ovf_clear_on_enable", ovf_s, 0);
        end
        motion_update_enable = 1'b0;
        in_data_valid = '0;
    endtask

    task automatic wait_swap(input string tag);
        int k = 0;
        while (swap_done !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_swap_done"}, swap_done, 1);
    endtask

    task automatic rd(input logic [7:0] a);
        in_read_address = a;
        in_rden = 1'b1;
        @(posedge clk); #1;
        in_rden = 1'b0;
    endtask

    task automatic check_bank(input string tag);
        int n = exp_q.size();
        check({tag, "_count"}, pcount, n);
        rd(8'd0);
        check({tag, "_swap_pulse"}, swap_done, 0);
        check({tag, "_addr0"}, out_info, n);
        for (int j = 1; j <= n; j++) begin
            rd(8'(j));
            check({tag, "_data"}, out_info, exp_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen_swap;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_swap_done", swap_done, 0);
        check("rst_count", pcount, 0);
        check("rst_overflow", ovf, 0);
        check("rst_out", out_info, 0);

        // Sparse hits on both channels, one shared cycle
        run_window(0, 10);
        check("basic_n_hits", exp_q.size(), 5);
        wait_swap("basic");
        check_bank("basic");
        check("basic_no_ovf", ovf, 0);

        // Back-to-back hits on both channels force backpressure
        run_window(1, 8);
        check("burst_ready_low", saw_not_ready, 1);
        wait_swap("burst");
        check_bank("burst");

        // Nothing addressed to this cell
        run_window(2, 10);
        wait_swap("empty");
        check_bank("empty");

        // Six hits: the PARTICLE_NUM=4 instance clips
        run_window(3, 5);
        wait_swap("ovf");
        check("ovf_small_count", pcount_s, 4);
`ifdef POS_CACHE_OVF_DETECT_EN
        check("ovf_small_flag", ovf_s, 1);
`else
        check("ovf_small_flag", ovf_s, 0);
`endif
        check("ovf_big_flag", ovf, 0);
        saved_q = exp_q;
        check_bank("ovf");

        // Reset while draining
        run_window(4, 4);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_count", pcount, 0);
        check("midrst_ovf_small", ovf_s, 0);
        rd(8'd0);
        check("midrst_bank0_addr0", out_info, 6);
        check("midrst_bank0_addr0_small", out_s, 4);
        rd(8'd3);
        check("midrst_bank0_addr3", out_info, saved_q[2]);
        check("midrst_bank0_addr3_small", out_s, saved_q[2]);
        @(posedge clk); #1;
        check("rd_hold", out_info, saved_q[2]);
        seen_swap = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (swap_done) seen_swap = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_swap", seen_swap, 0);

        // Update after the aborted one starts from a clean counter and queue
        run_window(5, 4);
        wait_swap("post_rst");
        check_bank("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
